display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexed 4-digit display scanner for the timer. It drives the `SEL` input of the 4-bit 4:1 digit mux and reads back the mux's `OUT` as the selected digit value. It produces active-low digit anode enables, a registered digit value for the segment decoder, and a once-per-frame tick. Each digit slot has an anti-ghosting blank gap and optional leading-zero suppression.

## Interface
Parameters:
- `REFRESH_DIV`, 50000 — cycles each digit is lit (≥1).
- `BLANK_CYCLES`, 500 — cycles with all anodes off before each digit lights (≥1).

Ports:
- `CLK` in 1 — single clock.
- `RST` in 1 — asynchronous, active-high reset.
- `EN` in 1 — scan enable; low forces display off.
- `LZB_EN` in 1 — leading-zero blanking enable.
- `MUX_OUT` in 4 — digit value returned by the digit mux for the current `SEL`.
- `SEL` out 2 — digit select to the mux; 3 = most significant.
- `AN_N` out 4 — active-low anode enables; bit i ↔ digit i.
- `DIGIT` out 4 — registered value of the lit digit.
- `FRAME` out 1 — one-cycle pulse at the end of digit 0's lit phase.

## Operation
- Reset values: `SEL`=3, `AN_N`=4'b1111, `DIGIT`=0, `FRAME`=0, state IDLE, counter 0, zero-run flag 1.
- States:
  - IDLE: anodes off. When `EN`=1, go to BLANK with `SEL`=3 and counter=0.
  - BLANK: `AN_N`=4'b1111 and `SEL` is stable, giving the combinational mux time to settle. Count `BLANK_CYCLES` cycles. On the last cycle, sample `MUX_OUT` into `DIGIT`, evaluate blanking, then go to ON.
  - ON: if the digit is not blanked, `AN_N` is all ones except bit `SEL`, which is 0. Count `REFRESH_DIV` cycles. On the last cycle: if `SEL`=0, pulse `FRAME` and set `SEL`=3; otherwise decrement `SEL`. Then go to BLANK.
- Scan order is 3,2,1,0,3,… and wraps with no extra cycles.
- Leading-zero blanking:
  - The zero-run flag is set to 1 whenever `SEL` is loaded with 3.
  - At the sample point, the digit is blanked iff `LZB_EN`=1, zero-run=1, `MUX_OUT`=0 and `SEL`≠0.
  - If not blanked, zero-run is cleared. A blanked digit keeps `AN_N`=4'b1111 through its ON phase.
  - Digit 0 is never blanked.
- `EN` falling in any state: on the next cycle the block enters IDLE, `AN_N`=4'b1111, `SEL`=3, counter=0, `FRAME`=0. `DIGIT` holds its value.
- `EN` rising restarts a fresh frame at digit 3's BLANK phase.
- `LZB_EN` and `MUX_OUT` are only used at the sample point. Changes at other times have no effect until the next slot.

## Timing
- One digit slot is `BLANK_CYCLES`+`REFRESH_DIV` cycles. One frame is 4× that.
- `SEL` changes on the same edge BLANK is entered. Anodes are off for the full BLANK phase.
- `DIGIT` and the anode decision are valid on the first ON cycle. The sample is taken on the last BLANK edge.
- `FRAME` is high for exactly the first cycle after the last ON cycle of digit 0, which is also the first BLANK cycle of digit 3.
- Counter width is `$clog2` of the larger parameter, plus 1. The terminal count is value −1.
- `RST` asserted at any time immediately forces the reset values. The first frame starts on the first edge after release when `EN`=1.
- All outputs are registered, with no combinational path from inputs.

## Structure
- Shared package `timer_pkg`: `NUM_DIGITS`=4, `DIGIT_W`=4, `SEL_W`=2, and the scan-state enum `scan_state_t` {IDLE, BLANK, ON}.
- Single module with no sub-modules. The slot counter and the zero-run flag are inline.
- The bench instantiates this block together with `mux_4bit_4_to_1` so the `SEL`/`OUT` loop is closed.

## Test plan
Use `REFRESH_DIV`=4 and `BLANK_CYCLES`=2, so a slot is 6 cycles and a frame is 24. Mux inputs are `IN_3..IN_0`.
- Reset: assert `RST` mid-ON → same cycle `AN_N`=4'b1111, `SEL`=3, `DIGIT`=0, `FRAME`=0.
- Normal scan, inputs 1,2,3,4, `LZB_EN`=0, `EN`=1:
  - Per slot: `AN_N` = 1111 ×2, then 0111 ×4 with `DIGIT`=1.
  - The same pattern follows for 1011/2, 1101/3 and 1110/4.
  - `FRAME` pulses every 24 cycles.
- Leading zeros, inputs 0,0,5,0, `LZB_EN`=1:
  - Digits 3 and 2 stay 1111.
  - Digit 1 lights with 5, and digit 0 lights with 0.
  - With inputs 0,0,0,0, only digit 0 lights.
- Same zero inputs with `LZB_EN`=0 → all four digits light with value 0.
- `EN` dropped during digit 2's ON phase → next cycle `AN_N`=1111 and `SEL`=3. Re-asserting `EN` gives 2 blank cycles, then digit 3 lit.
- Change `IN_3` from 1 to 7 during digit 3's ON phase → `DIGIT` stays 1 until that digit's next sample, one frame later.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Definitions shared by the timer display path: the digit count, digit and
// select widths, the scan-state encoding, and a helper that turns a digit
// select into its active-low anode pattern.
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    // Active-low one-cold anode pattern that lights only digit `sel`.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [SEL_W-1:0] sel);
        logic [NUM_DIGITS-1:0] one_hot;
        one_hot = '0;
        one_hot[sel] = 1'b1;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/mux_4bit_4_to_1.sv
// -----------------------------------------------------------------------------
// mux_4bit_4_to_1
// Purely combinational 4:1 selector of 4-bit digit values. The scan
// controller drives SEL and reads OUT back as the value of the selected digit.
//
// Ports:
//   SEL         in  2  digit select (3 = most significant)
//   IN_3..IN_0  in  4  digit values
//   OUT         out 4  value of the selected digit
// -----------------------------------------------------------------------------
module mux_4bit_4_to_1
    import timer_pkg::*;
(
    input  logic [SEL_W-1:0]   SEL,
    input  logic [DIGIT_W-1:0] IN_3,
    input  logic [DIGIT_W-1:0] IN_2,
    input  logic [DIGIT_W-1:0] IN_1,
    input  logic [DIGIT_W-1:0] IN_0,
    output logic [DIGIT_W-1:0] OUT
);

    always_comb begin
        case (SEL)
            2'd3:    OUT = IN_3;
            2'd2:    OUT = IN_2;
            2'd1:    OUT = IN_1;
            default: OUT = IN_0;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scanner for a 4-digit display. Each digit slot is a BLANK
// phase (all anodes off while the external digit mux settles on the new SEL)
// followed by an ON phase (the digit's anode is driven low). The digit value
// is sampled on the last BLANK edge, together with the leading-zero blanking
// decision. Scan order is 3,2,1,0 and FRAME pulses as digit 3's BLANK begins
// after digit 0 has been shown.
//
// Ports:
//   CLK      in  1  clock
//   RST      in  1  asynchronous active-high reset
//   EN       in  1  scan enable; low turns the display off and parks on digit 3
//   LZB_EN   in  1  leading-zero blanking enable (used only at the sample point)
//   MUX_OUT  in  4  digit value returned by the digit mux for the current SEL
//   SEL      out 2  digit select to the mux (3 = most significant)
//   AN_N     out 4  active-low anode enables, bit i <-> digit i
//   DIGIT    out 4  registered value of the lit digit
//   FRAME    out 1  one-cycle pulse once per frame
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import timer_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  LZB_EN,
    input  logic [DIGIT_W-1:0]    MUX_OUT,
    output logic [SEL_W-1:0]      SEL,
    output logic [NUM_DIGITS-1:0] AN_N,
    output logic [DIGIT_W-1:0]    DIGIT,
    output logic                  FRAME
);

    localparam int MAX_DIV = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_DIV) + 1;

    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_MSD      = SEL_W'(NUM_DIGITS - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    // Set while every digit examined so far in this frame has been blanked.
    logic             zero_run;
    logic             blank_digit;

    // Blanking decision for the digit currently on the mux; only consumed on
    // the last BLANK cycle. Digit 0 is always shown so a zero reading is "0".
    assign blank_digit = LZB_EN && zero_run && (MUX_OUT == '0) && (SEL != '0);

    // NOTE: every register here is updated with non-blocking assignments so
    // that all of them see the pre-edge values of state, cnt and SEL, which is
    // what makes the sample/anode decision and the SEL step coherent.
    // NOTE: the reset branch is asynchronous so the anodes go dark the moment
    // RST rises, without waiting for a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            SEL      <= SEL_MSD;
            AN_N     <= '1;
            DIGIT    <= '0;
            FRAME    <= 1'b0;
            zero_run <= 1'b1;
        end else if (!EN) begin
            // DIGIT is deliberately left holding its last value.
            state    <= IDLE;
            cnt      <= '0;
            SEL      <= SEL_MSD;
            AN_N     <= '1;
            FRAME    <= 1'b0;
            zero_run <= 1'b1;
        end else begin
            FRAME <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= BLANK;
                    cnt      <= '0;
                    SEL      <= SEL_MSD;
                    AN_N     <= '1;
                    zero_run <= 1'b1;
                end

                BLANK: begin
                    AN_N <= '1;
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= ON;
                        DIGIT <= MUX_OUT;
                        if (!blank_digit) begin
                            zero_run <= 1'b0;
                            AN_N     <= anode_for(SEL);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ON: begin
                    if (cnt == REFRESH_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                        AN_N  <= '1;
                        if (SEL == '0) begin
                            // Wrap straight into digit 3's BLANK phase.
                            FRAME    <= 1'b1;
                            SEL      <= SEL_MSD;
                            zero_run <= 1'b1;
                        end else begin
                            SEL <= SEL - 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    SEL   <= SEL_MSD;
                    AN_N  <= '1;
                end
            endcase
        end
    end

endmodule
